uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Accepts 9-bit characters on the receiver's rf_write / rf_wbyte / rf_full interface and holds them in a circular FIFO.
- Presents them first-word-fall-through to the bus register block.
- Also generates the receive level-threshold flag, the sticky overflow flag and the character-timeout flag, measured in bit times.

---
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through read port,
// level threshold, sticky overflow and character-timeout flags.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_n,
  input  logic [23:0]           ckdiv,
  input  logic [7:0]            totime,
  input  logic [DEPTH_LOG2:0]   rxthr,
  input  logic                  rf_write,
  input  logic [DW-1:0]         rf_wbyte,
  output logic                  rf_full,
  input  logic                  rd_en,
  output logic [DW-1:0]         rd_data,
  output logic                  rf_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  thr_hit,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          thr_q, thr_d, ovf_q, ovf_d, to_q, to_d;
  logic [23:0]   divcnt_q, divcnt_d;
  logic [7:0]    idle_q, idle_d;
  logic          wr_acc, rd_acc, tick;

  always_comb begin
    wr_acc  = rf_write & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    wptr_d  = wptr_q + {{(PW-1){1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{(PW-1){1'b0}}, rd_acc};
    level_d = wptr_d - rptr_d;
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
    thr_d   = (rxthr != '0) && (level_d >= rxthr);

    // A write against a full FIFO is judged before any same-cycle pop.
    ovf_d = ovf_q;
    if (rf_write && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    tick     = (divcnt_q == '0);
    divcnt_d = divcnt_q;
    idle_d   = idle_q;
    to_d     = to_q;
    if (wr_acc || rd_acc || empty_q) begin
      divcnt_d = ckdiv;
      idle_d   = '0;
      to_d     = 1'b0;
    end else if (!to_q) begin
      if (tick) begin
        divcnt_d = ckdiv;
        idle_d   = idle_q + 8'd1;
        to_d     = (totime != '0) && (idle_d >= totime);
      end else begin
        divcnt_d = divcnt_q - 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      thr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      divcnt_q <= '0;
      idle_q   <= '0;
    end else if (!clr_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      thr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      divcnt_q <= '0;
      idle_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      thr_q    <= thr_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      divcnt_q <= divcnt_d;
      idle_q   <= idle_d;
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (wr_acc && clr_n) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= rf_wbyte;
    end
  end

  assign rd_data  = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign rf_full  = full_q;
  assign rf_empty = empty_q;
  assign level    = level_q;
  assign thr_hit  = thr_q;
  assign overflow = ovf_q;
  assign timeout  = to_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_n = 1'b1;
  logic [23:0] ckdiv = 24'd9;
  logic [7:0]  totime = 8'd0;
  logic [4:0]  rxthr = 5'd0;
  logic        rf_write = 1'b0;
  logic [8:0]  rf_wbyte = 9'd0;
  logic        rd_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        rf_full, rf_empty, thr_hit, overflow, timeout;
  logic [8:0]  rd_data;
  logic [4:0]  level;

  int nvec = 0;
  int nerr = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DW(9)) dut (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .ckdiv(ckdiv), .totime(totime),
    .rxthr(rxthr), .rf_write(rf_write), .rf_wbyte(rf_wbyte), .rf_full(rf_full),
    .rd_en(rd_en), .rd_data(rd_data), .rf_empty(rf_empty), .level(level),
    .thr_hit(thr_hit), .overflow(overflow), .ovf_clr(ovf_clr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, timeout as cycles since last activity.
  int unsigned m_q[$];
  bit          m_ovf, m_to, m_thr, m_full, m_wacc, m_racc;
  longint      m_idle;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || !clr_n) begin
      m_q.delete();
      m_ovf  = 0;
      m_to   = 0;
      m_thr  = 0;
      m_idle = 0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      m_wacc = rf_write && !m_full;
      m_racc = rd_en && (m_q.size() != 0);
      if (rf_write && m_full) m_ovf = 1;
      else if (ovf_clr)       m_ovf = 0;
      if (m_racc) void'(m_q.pop_front());
      if (m_wacc) m_q.push_back(int'(rf_wbyte));
      if (m_wacc || m_racc || m_q.size() == 0) begin
        m_idle = 0;
        m_to   = 0;
      end else if (!m_to) begin
        m_idle++;
        if (totime != 0 && m_idle == (longint'(ckdiv) + 1) * longint'(totime)) m_to = 1;
      end
      m_thr = (rxthr != 0) && (m_q.size() >= int'(rxthr));
    end
  end

  initial forever begin
    @(negedge clk);
    chk("level",    32'(level),    32'(m_q.size()));
    chk("rf_empty", 32'(rf_empty), 32'(m_q.size() == 0));
    chk("rf_full",  32'(rf_full),  32'(m_q.size() == DEPTH));
    chk("thr_hit",  32'(thr_hit),  32'(m_thr));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("timeout",  32'(timeout),  32'(m_to));
    if (m_q.size() != 0) chk("rd_data", 32'(rd_data), m_q[0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] d);
    rf_write = 1'b1;
    rf_wbyte = d;
    cyc();
    rf_write = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  found;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(rf_empty), 1);
    chk("rst_full", 32'(rf_full), 0);
    chk("rst_flags", {29'd0, thr_hit, overflow, timeout}, 0);

    for (int i = 0; i < 16; i++) begin
      push(9'(9'h100 + i));
      if (i == 0) chk("first_rd_data", 32'(rd_data), 32'h100);
      chk("fill_level", 32'(level), 32'(i + 1));
    end
    chk("full_after_16", 32'(rf_full), 1);
    chk("thr_disabled", 32'(thr_hit), 0);

    rf_write = 1'b1; rf_wbyte = 9'h1AA; rd_en = 1'b1;
    cyc();
    rf_write = 1'b0; rd_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 15);
    chk("ovf_head", 32'(rd_data), 32'h101);
    for (int i = 0; i < 15; i++) begin
      chk("drain_data", 32'(rd_data), 32'(32'h101 + i));
      pop();
    end
    chk("drained_empty", 32'(rf_empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    rxthr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      push(9'(9'h010 + i));
      chk("thr_rise", 32'(thr_hit), 32'(i == 3));
    end
    pop();
    chk("thr_fall", 32'(thr_hit), 0);
    chk("thr_level3", 32'(level), 3);
    for (int i = 0; i < 5; i++) push(9'(9'h014 + i));
    chk("stream_start_level", 32'(level), 8);

    rf_write = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rf_wbyte = 9'(9'h040 + i);
      cyc();
      chk("stream_level", 32'(level), 8);
    end
    rf_write = 1'b0; rd_en = 1'b0;
    chk("stream_head", 32'(rd_data), 32'h060);

    repeat (8) pop();
    chk("empty_before_to", 32'(rf_empty), 1);
    rxthr = 5'd0;
    ckdiv = 24'd9; totime = 8'd3;
    push(9'h033);
    n = 0; found = 0;
    while (n < 100 && !found) begin
      cyc();
      n++;
      if (timeout) found = 1;
    end
    chk("to_latency", 32'(n), 30);
    pop();
    chk("to_clr_by_rd", 32'(timeout), 0);

    totime = 8'd0;
    push(9'h044);
    repeat (60) cyc();
    chk("to_disabled", 32'(timeout), 0);

    totime = 8'd3;
    for (int i = 0; i < 15; i++) push(9'(9'h080 + i));
    chk("refill_full", 32'(rf_full), 1);
    push(9'h1EE);
    chk("refill_ovf", 32'(overflow), 1);
    repeat (11) pop();
    chk("pre_clr_level", 32'(level), 5);
    repeat (30) cyc();
    chk("pre_clr_to", 32'(timeout), 1);

    clr_n = 1'b0; rf_write = 1'b1; rf_wbyte = 9'h1FF;
    cyc();
    clr_n = 1'b1; rf_write = 1'b0;
    chk("clr_level", 32'(level), 0);
    chk("clr_empty", 32'(rf_empty), 1);
    chk("clr_flags", {28'd0, rf_full, thr_hit, overflow, timeout}, 0);
    cyc();
    chk("clr_write_dropped", 32'(rf_empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
